fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/common_pkg.sv | 22 ++
 rtl/fetch_skid.sv | 38 +++
 rtl/fetch_stage.sv | 187 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared fetch-path types and constants.
package common;

  typedef logic [31:0] word_t;
  typedef logic [31:0] instr_t;

  // REQ: issuing, WAIT: one request outstanding, FULL: skid occupied, HALT: parked after fault
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    FULL = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  localparam word_t BOOT_PC_DEFAULT = 32'h0000_1000;

  // Sequential fetch increment; wraps modulo 2^32 naturally.
  function automatic word_t pc_incr(input word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a response that arrived while IF/ID was stalled.
module fetch_skid
  import common::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   drain,
  input  logic   flush,
  input  instr_t in_data,
  input  word_t  in_pc,
  input  logic   in_fault,
  output logic   valid,
  output instr_t data,
  output word_t  pc,
  output logic   fault
);

  // Flush wins over load, load wins over drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
      fault <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= in_data;
      pc    <= in_pc;
      fault <= in_fault;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding icache requester feeding the IF/ID register.
module fetch_stage
  import common::*;
#(
  parameter word_t BOOT_PC = BOOT_PC_DEFAULT
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   stall,
  input  logic   redirect_valid,
  input  word_t  redirect_pc,
  output logic   icache_req_valid,
  output word_t  icache_req_addr,
  input  logic   icache_req_ready,
  input  logic   icache_resp_valid,
  input  instr_t icache_resp_data,
  input  logic   icache_resp_fault,
  output logic   instr_valid,
  output instr_t instruction,
  output word_t  instr_pc,
  output logic   instr_fault
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  logic         kill_q, kill_d;

  logic         ifid_valid_q, ifid_valid_d;
  instr_t       ifid_data_q, ifid_data_d;
  word_t        ifid_pc_q, ifid_pc_d;
  logic         ifid_fault_q, ifid_fault_d;

  logic         skid_valid;
  instr_t       skid_data;
  word_t        skid_pc;
  logic         skid_fault;

  logic         ifid_open;
  logic         resp_take;
  logic         resp_to_skid;
  logic         skid_drain;

  // IF/ID may accept a new entry when it is empty or the decoder is consuming it.
  assign ifid_open    = !ifid_valid_q || !stall;
  // A live response: in WAIT, not killed by an earlier redirect, not discarded by one now.
  assign resp_take    = (state_q == WAIT) && icache_resp_valid && !kill_q && !redirect_valid;
  assign resp_to_skid = resp_take && !ifid_open;
  assign skid_drain   = skid_valid && ifid_open && !redirect_valid;

  // Request is gated by rst_n so nothing is presented to the icache while in reset.
  assign icache_req_valid = rst_n && (state_q == REQ);
  assign icache_req_addr  = pc_q;

  assign instr_valid = ifid_valid_q;
  assign instruction = ifid_data_q;
  assign instr_pc    = ifid_pc_q;
  assign instr_fault = ifid_fault_q;

  fetch_skid u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (resp_to_skid),
    .drain    (skid_drain),
    .flush    (redirect_valid),
    .in_data  (icache_resp_data),
    .in_pc    (pc_q),
    .in_fault (icache_resp_fault),
    .valid    (skid_valid),
    .data     (skid_data),
    .pc       (skid_pc),
    .fault    (skid_fault)
  );

  // FSM, PC and kill next-state; redirect has priority over everything else.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    unique case (state_q)
      REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (icache_req_ready) begin
            // Request already accepted by the icache; its response must be dropped.
            state_d = WAIT;
            kill_d  = 1'b1;
          end else begin
            state_d = REQ;
            kill_d  = 1'b0;
          end
        end else if (icache_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (icache_resp_valid) begin
            state_d = REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d = 1'b1;
          end
        end else if (icache_resp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else if (icache_resp_fault) begin
            state_d = HALT;
          end else begin
            pc_d    = pc_incr(pc_q);
            state_d = resp_to_skid ? FULL : REQ;
          end
        end
      end
      FULL: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = REQ;
        end else if (ifid_open) begin
          state_d = REQ;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  // IF/ID next-state: skid entry is older than any response, so it goes first.
  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_data_d  = ifid_data_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_fault_d = ifid_fault_q;
    if (redirect_valid) begin
      ifid_valid_d = 1'b0;
    end else if (ifid_open) begin
      if (skid_valid) begin
        ifid_valid_d = 1'b1;
        ifid_data_d  = skid_data;
        ifid_pc_d    = skid_pc;
        ifid_fault_d = skid_fault;
      end else if (resp_take) begin
        ifid_valid_d = 1'b1;
        ifid_data_d  = icache_resp_data;
        ifid_pc_d    = pc_q;
        ifid_fault_d = icache_resp_fault;
      end else begin
        ifid_valid_d = 1'b0;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q    <= BOOT_PC;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid_q <= 1'b0;
      ifid_data_q  <= '0;
      ifid_pc_q    <= '0;
      ifid_fault_q <= 1'b0;
    end else begin
      ifid_valid_q <= ifid_valid_d;
      ifid_data_q  <= ifid_data_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_fault_q <= ifid_fault_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed cycle-table bench for fetch_stage; icache behaviour is scripted per row.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        icache_req_valid;
  logic [31:0] icache_req_addr;
  logic        icache_req_ready;
  logic        icache_resp_valid;
  logic [31:0] icache_resp_data;
  logic        icache_resp_fault;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_fault;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall             (stall),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .icache_req_valid  (icache_req_valid),
    .icache_req_addr   (icache_req_addr),
    .icache_req_ready  (icache_req_ready),
    .icache_resp_valid (icache_resp_valid),
    .icache_resp_data  (icache_resp_data),
    .icache_resp_fault (icache_resp_fault),
    .instr_valid       (instr_valid),
    .instruction       (instruction),
    .instr_pc          (instr_pc),
    .instr_fault       (instr_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: inputs driven for this cycle, outputs expected during it.
  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        rsv;
    logic [31:0] rsd;
    logic        rsf;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic [31:0] e_ins;
    logic        e_flt;
  } vec_t;

  vec_t vq[$];

  task automatic row(input logic st, input logic rv, input logic [31:0] rpc, input logic rdy,
                     input logic rsv, input logic [31:0] rsd, input logic rsf,
                     input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                     input logic [31:0] e_ipc, input logic [31:0] e_ins, input logic e_flt);
    vec_t v;
    v.stall = st; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.rsv = rsv; v.rsd = rsd; v.rsf = rsf;
    v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv;
    v.e_ipc = e_ipc; v.e_ins = e_ins; v.e_flt = e_flt;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; redirect_valid = 0; redirect_pc = 0; icache_req_ready = 0;
    icache_resp_valid = 0; icache_resp_data = 0; icache_resp_fault = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    //       st rv rpc           rdy rsv rsd           rsf  req addr          iv ipc           ins           flt
    // streaming from boot
    row(0, 0, 0,             1, 0, 0,             0,   1, 32'h0000_1000, 0, 0,             0,             0); // 0
    row(0, 0, 0,             0, 1, 32'hC0DE_0000, 0,   0, 0,             0, 0,             0,             0); // 1
    row(0, 0, 0,             1, 0, 0,             0,   1, 32'h0000_1004, 1, 32'h0000_1000, 32'hC0DE_0000, 0); // 2
    row(0, 0, 0,             0, 1, 32'hC0DE_0001, 0,   0, 0,             0, 0,             0,             0); // 3
    row(0, 0, 0,             1, 0, 0,             0,   1, 32'h0000_1008, 1, 32'h0000_1004, 32'hC0DE_0001, 0); // 4
    row(0, 0, 0,             0, 1, 32'hC0DE_0002, 0,   0, 0,             0, 0,             0,             0); // 5
    // stall for 4 cycles: response goes to skid, FULL issues nothing
    row(1, 0, 0,             1, 0, 0,             0,   1, 32'h0000_100C, 1, 32'h0000_1008, 32'hC0DE_0002, 0); // 6
    row(1, 0, 0,             0, 1, 32'hC0DE_0003, 0,   0, 0,             1, 32'h0000_1008, 32'hC0DE_0002, 0); // 7
    row(1, 0, 0,             1, 0, 0,             0,   0, 0,             1, 32'h0000_1008, 32'hC0DE_0002, 0); // 8
    row(1, 0, 0,             1, 0, 0,             0,   0, 0,             1, 32'h0000_1008, 32'hC0DE_0002, 0); // 9
    row(0, 0, 0,             1, 0, 0,             0,   0, 0,             1, 32'h0000_1008, 32'hC0DE_0002, 0); // 10
    row(0, 0, 0,             0, 0, 0,             0,   1, 32'h0000_1010, 1, 32'h0000_100C, 32'hC0DE_0003, 0); // 11
    row(0, 0, 0,             1, 0, 0,             0,   1, 32'h0000_1010, 0, 0,             0,             0); // 12
    row(0, 0, 0,             0, 1, 32'hC0DE_0004, 0,   0, 0,             0, 0,             0,             0); // 13
    row(0, 0, 0,             1, 0, 0,             0,   1, 32'h0000_1014, 1, 32'h0000_1010, 32'hC0DE_0004, 0); // 14
    // redirect in WAIT without response: stale response dropped
    row(0, 1, 32'h0000_2000, 0, 0, 0,             0,   0, 0,             0, 0,             0,             0); // 15
    row(0, 0, 0,             0, 1, 32'hC0DE_0005, 0,   0, 0,             0, 0,             0,             0); // 16
    row(0, 0, 0,             1, 0, 0,             0,   1, 32'h0000_2000, 0, 0,             0,             0); // 17
    row(0, 0, 0,             0, 1, 32'hC0DE_0006, 0,   0, 0,             0, 0,             0,             0); // 18
    // redirect coinciding with response under stall
    row(1, 0, 0,             1, 0, 0,             0,   1, 32'h0000_2004, 1, 32'h0000_2000, 32'hC0DE_0006, 0); // 19
    row(1, 1, 32'h0000_2400, 0, 1, 32'hC0DE_0007, 0,   0, 0,             1, 32'h0000_2000, 32'hC0DE_0006, 0); // 20
    row(0, 0, 0,             1, 0, 0,             0,   1, 32'h0000_2400, 0, 0,             0,             0); // 21
    row(0, 0, 0,             0, 1, 32'hC0DE_0008, 0,   0, 0,             0, 0,             0,             0); // 22
    // redirect in REQ (not accepted), then fault at 0x1008
    row(0, 1, 32'h0000_1000, 0, 0, 0,             0,   1, 32'h0000_2404, 1, 32'h0000_2400, 32'hC0DE_0008, 0); // 23
    row(0, 0, 0,             1, 0, 0,             0,   1, 32'h0000_1000, 0, 0,             0,             0); // 24
    row(0, 0, 0,             0, 1, 32'hC0DE_0009, 0,   0, 0,             0, 0,             0,             0); // 25
    row(0, 0, 0,             1, 0, 0,             0,   1, 32'h0000_1004, 1, 32'h0000_1000, 32'hC0DE_0009, 0); // 26
    row(0, 0, 0,             0, 1, 32'hC0DE_000A, 0,   0, 0,             0, 0,             0,             0); // 27
    row(0, 0, 0,             1, 0, 0,             0,   1, 32'h0000_1008, 1, 32'h0000_1004, 32'hC0DE_000A, 0); // 28
    row(0, 0, 0,             0, 1, 32'hDEAD_BEEF, 1,   0, 0,             0, 0,             0,             0); // 29
    row(0, 0, 0,             1, 0, 0,             0,   0, 0,             1, 32'h0000_1008, 0,             1); // 30
    row(0, 0, 0,             1, 0, 0,             0,   0, 0,             0, 0,             0,             0); // 31
    row(0, 1, 32'h0000_3000, 1, 0, 0,             0,   0, 0,             0, 0,             0,             0); // 32
    row(0, 0, 0,             1, 0, 0,             0,   1, 32'h0000_3000, 0, 0,             0,             0); // 33
    row(0, 0, 0,             0, 1, 32'hC0DE_000B, 0,   0, 0,             0, 0,             0,             0); // 34
    // PC wrap at top of address space
    row(0, 1, 32'hFFFF_FFFC, 0, 0, 0,             0,   1, 32'h0000_3004, 1, 32'h0000_3000, 32'hC0DE_000B, 0); // 35
    row(0, 0, 0,             1, 0, 0,             0,   1, 32'hFFFF_FFFC, 0, 0,             0,             0); // 36
    row(0, 0, 0,             0, 1, 32'hC0DE_000C, 0,   0, 0,             0, 0,             0,             0); // 37
    // redirect coinciding with req_ready: request counted as accepted, response killed
    row(0, 1, 32'h0000_4000, 1, 0, 0,             0,   1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'hC0DE_000C, 0); // 38
    row(0, 0, 0,             0, 1, 32'hC0DE_000D, 0,   0, 0,             0, 0,             0,             0); // 39
    row(0, 0, 0,             1, 0, 0,             0,   1, 32'h0000_4000, 0, 0,             0,             0); // 40
    row(0, 0, 0,             0, 1, 32'hC0DE_000E, 0,   0, 0,             0, 0,             0,             0); // 41
    row(0, 0, 0,             1, 0, 0,             0,   1, 32'h0000_4004, 1, 32'h0000_4000, 32'hC0DE_000E, 0); // 42

    // Reset state
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("reset req_valid", {31'd0, icache_req_valid}, 32'd0);
    chk("reset instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("reset instr_fault", {31'd0, instr_fault}, 32'd0);
    chk("reset instruction", instruction, 32'd0);
    chk("reset instr_pc", instr_pc, 32'd0);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      stall             = vq[i].stall;
      redirect_valid    = vq[i].rv;
      redirect_pc       = vq[i].rpc;
      icache_req_ready  = vq[i].rdy;
      icache_resp_valid = vq[i].rsv;
      icache_resp_data  = vq[i].rsd;
      icache_resp_fault = vq[i].rsf;
      #1;
      chk($sformatf("c%0d req_valid", i), {31'd0, icache_req_valid}, {31'd0, vq[i].e_req});
      if (vq[i].e_req)
        chk($sformatf("c%0d req_addr", i), icache_req_addr, vq[i].e_addr);
      chk($sformatf("c%0d instr_valid", i), {31'd0, instr_valid}, {31'd0, vq[i].e_iv});
      if (vq[i].e_iv) begin
        chk($sformatf("c%0d instr_pc", i), instr_pc, vq[i].e_ipc);
        chk($sformatf("c%0d instr_fault", i), {31'd0, instr_fault}, {31'd0, vq[i].e_flt});
        if (!vq[i].e_flt)
          chk($sformatf("c%0d instruction", i), instruction, vq[i].e_ins);
      end
      @(negedge clk);
    end

    // Reset asserted with a request outstanding (FSM in WAIT after row 42).
    idle_inputs();
    #1;
    chk("midreset pre req_valid", {31'd0, icache_req_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midreset req_valid", {31'd0, icache_req_valid}, 32'd0);
    chk("midreset instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("midreset instr_pc", instr_pc, 32'd0);
    chk("midreset instruction", instruction, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post reset req_valid", {31'd0, icache_req_valid}, 32'd1);
    chk("post reset req_addr", icache_req_addr, 32'h0000_1000);
    // Request held stable while icache is not ready.
    @(negedge clk);
    #1;
    chk("held req_valid", {31'd0, icache_req_valid}, 32'd1);
    chk("held req_addr", icache_req_addr, 32'h0000_1000);
    icache_req_ready = 1'b1;
    @(negedge clk);
    icache_req_ready = 1'b0;
    icache_resp_valid = 1'b1;
    icache_resp_data = 32'h0BAD_F00D;
    #1;
    chk("post reset wait req_valid", {31'd0, icache_req_valid}, 32'd0);
    @(negedge clk);
    icache_resp_valid = 1'b0;
    #1;
    chk("post reset instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("post reset instruction", instruction, 32'h0BAD_F00D);
    chk("post reset instr_pc", instr_pc, 32'h0000_1000);
    chk("post reset next addr", icache_req_addr, 32'h0000_1004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
